// File: rtl/survivor_traceback_reader.sv
// survivor_traceback_reader: walks a Viterbi survivor RAM backwards from a
// start stage/state, emitting one traced bit per stage.
// Ports: Clock1/Reset (async, active-low); Start/StartStage/StartState
// request a traceback; RamRd/RamAddr/RamData form the survivor RAM read
// port (data one cycle after RamRd); TbBit/TbValid carry traced bits;
// Busy, Done and FinalState report progress and the end state.
// Option: define SURV_RD_DATA_REG_EN to register RamData before bit
// selection (3 cycles per stage instead of 2, same results).
module survivor_traceback_reader #(
    parameter int N_ACS          = 4,
    parameter int WD_RAM_DATA    = 8,
    parameter int WD_STATE       = 6,
    parameter int WD_STAGE       = 5,
    parameter int WD_RAM_ADDRESS = 8,
    parameter int TB_LEN         = 20
) (
    input  logic                      Clock1,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [WD_STAGE-1:0]       StartStage,
    input  logic [WD_STATE-1:0]       StartState,
    output logic                      RamRd,
    output logic [WD_RAM_ADDRESS-1:0] RamAddr,
    input  logic [WD_RAM_DATA-1:0]    RamData,
    output logic                      TbBit,
    output logic                      TbValid,
    output logic                      Busy,
    output logic                      Done,
    output logic [WD_STATE-1:0]       FinalState
);

    // Low state bits pick a bit inside the word, high bits pick the word.
    localparam int WD_SEL = $clog2(WD_RAM_DATA);
    localparam int WD_CNT = WD_STAGE + 1;
    localparam logic [WD_CNT-1:0] CNT_LAST = WD_CNT'(TB_LEN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_SEL   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef SURV_RD_DATA_REG_EN
    localparam logic [2:0] S_LATCH = 3'd2;
`endif

    logic [2:0]          fsm_q,      fsm_d;
    logic [WD_STAGE-1:0] stage_q,    stage_d;
    logic [WD_STATE-1:0] state_q,    state_d;
    logic [WD_CNT-1:0]   cnt_q,      cnt_d;
    logic                tb_bit_q,   tb_bit_d;
    logic                tb_valid_q, tb_valid_d;
    logic [WD_STATE-1:0] final_q,    final_d;
    logic [WD_RAM_DATA-1:0] sel_word;
    logic                   sel_bit;

`ifdef SURV_RD_DATA_REG_EN
    logic [WD_RAM_DATA-1:0] data_q, data_d;
    assign sel_word = data_q;
`else
    assign sel_word = RamData;
`endif

    assign sel_bit = sel_word[state_q[WD_SEL-1:0]];

    always_comb begin
        fsm_d      = fsm_q;
        stage_d    = stage_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        tb_bit_d   = tb_bit_q;
        tb_valid_d = 1'b0;
        final_d    = final_q;
`ifdef SURV_RD_DATA_REG_EN
        data_d     = data_q;
`endif
        case (fsm_q)
            S_IDLE: begin
                if (Start) begin
                    stage_d = StartStage;
                    state_d = StartState;
                    cnt_d   = '0;
                    fsm_d   = S_READ;
                end
            end
            S_READ: begin
`ifdef SURV_RD_DATA_REG_EN
                fsm_d = S_LATCH;
`else
                fsm_d = S_SEL;
`endif
            end
`ifdef SURV_RD_DATA_REG_EN
            S_LATCH: begin
                data_d = RamData;
                fsm_d  = S_SEL;
            end
`endif
            S_SEL: begin
                // Shift the survivor bit in as the new MSB: previous state.
                state_d    = {sel_bit, state_q[WD_STATE-1:1]};
                stage_d    = stage_q - 1'b1;
                tb_bit_d   = sel_bit;
                tb_valid_d = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_d == CNT_LAST) begin
                    final_d = state_d;
                    fsm_d   = S_DONE;
                end else begin
                    fsm_d = S_READ;
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock1 or negedge Reset) begin
        if (!Reset) begin
            fsm_q      <= S_IDLE;
            stage_q    <= '0;
            state_q    <= '0;
            cnt_q      <= '0;
            tb_bit_q   <= 1'b0;
            tb_valid_q <= 1'b0;
            final_q    <= '0;
`ifdef SURV_RD_DATA_REG_EN
            data_q     <= '0;
`endif
        end else begin
            fsm_q      <= fsm_d;
            stage_q    <= stage_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tb_bit_q   <= tb_bit_d;
            tb_valid_q <= tb_valid_d;
            final_q    <= final_d;
`ifdef SURV_RD_DATA_REG_EN
            data_q     <= data_d;
`endif
        end
    end

    assign RamRd      = (fsm_q == S_READ);
    assign RamAddr    = {stage_q, state_q[WD_STATE-1:WD_SEL]};
    assign TbBit      = tb_bit_q;
    assign TbValid    = tb_valid_q;
    assign Busy       = (fsm_q != S_IDLE);
    assign Done       = (fsm_q == S_DONE);
    assign FinalState = final_q;

endmodule

// File: doc/survivor_traceback_reader.md
# survivor_traceback_reader

- Traceback-side consumer of the survivor RAM.
- Takes a start stage and state, reads one survivor word per trellis stage and extracts the survivor bit of the current state.
- Walks the state backwards for a fixed number of stages, emitting one traced bit per stage.
- Sits between the survivor RAM read port and the decoded-bit output logic: it is the read end of the packed `{current, previous}` survivor words written by the ACS survivor buffer.

## Interface
Parameters:
- N_ACS, 4: survivor bits produced per ACS cycle; a RAM word holds two cycles' worth.
- WD_RAM_DATA, 8: RAM word width; must equal 2*N_ACS.
- WD_STATE, 6: trellis state width (64 states); state[2:0] selects the bit, state[5:3] selects the word.
- WD_STAGE, 5: stage index width; circular buffer of 32 stages.
- WD_RAM_ADDRESS, 8: must equal WD_STAGE + WD_STATE - log2(WD_RAM_DATA).
- TB_LEN, 20: stages traced per Start; range 1..2^WD_STAGE.

Ports:
- Clock1  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low.
- Start  in  1  one-cycle request; sampled only when Busy=0.
- StartStage  in  WD_STAGE  first stage to read.
- StartState  in  WD_STATE  state at StartStage.
- RamRd  out  1  read strobe to survivor RAM.
- RamAddr  out  WD_RAM_ADDRESS  equals {stage, state[WD_STATE-1:3]}.
- RamData  in  WD_RAM_DATA  read data, valid the cycle after RamRd.
- TbBit  out  1  traced survivor bit.
- TbValid  out  1  one-cycle qualifier for TbBit.
- Busy  out  1  traceback in progress.
- Done  out  1  one-cycle pulse after the last bit.
- FinalState  out  WD_STATE  state after the last step; held until the next Start.

## Operation
FSM states:
- IDLE:
  - Start=1 latches StartStage into stage, StartState into state, and loads step count 0.
  - Goes to READ.
- READ:
  - RamRd=1, RamAddr={stage, state[5:3]}.
  - Goes to SEL.
- SEL:
  - bit = RamData[state[2:0]].
  - Next state = {bit, state[WD_STATE-1:1]}.
  - stage decrements by 1, wrapping 0 to 2^WD_STAGE-1.
  - TbBit=bit and TbValid=1 are registered out.
  - Count increments. If count reaches TB_LEN go to DONE, else go to READ.
- DONE:
  - Done=1 for one cycle, FinalState updated, Busy drops.
  - Goes to IDLE.

General rules:
- Start while Busy=1 is ignored; no queuing.
- Start in the same cycle as Done is ignored, because Busy is still 1.
- RamData is don't-care outside the cycle after RamRd.
- Reset asserted mid-traceback aborts immediately: FSM to IDLE, all outputs to reset values, no Done.

## Timing
- Reset values:
  - RamRd=0, RamAddr=0, TbBit=0, TbValid=0, Busy=0, Done=0, FinalState=0.
  - Internal stage, state and count are also 0.
- Busy rises in the cycle after the Start edge and falls in the cycle after Done.
- Default build:
  - First RamRd is in the cycle after Start.
  - 2 cycles per stage.
  - The TbValid for step k is coincident with the RamRd for step k+1.
  - Done is 2*TB_LEN+1 cycles after Start.
- RamRd is never high in two consecutive cycles.
- TbValid pulses exactly TB_LEN times per traceback.

## Configuration
- SURV_RD_DATA_REG_EN:
  - When defined, RamData is registered in an extra LATCH state between READ and SEL.
  - This gives 3 cycles per stage and Done 3*TB_LEN+1 cycles after Start.
  - Bit selection uses the registered word.
- When not defined, SEL samples RamData directly at 2 cycles per stage.
- Functional results are identical in both builds.

## Test plan
- Reset low at t=0, then high: all outputs 0. Start while Reset=0: no RamRd.
- Single step, TB_LEN=1, StartStage=3, StartState=45, RamData=8'h20:
  - RamAddr=8'h1D, TbBit=1, FinalState=54.
  - Done 3 cycles after Start (4 with SURV_RD_DATA_REG_EN).
- Stage wrap: StartStage=0, TB_LEN=3:
  - RamAddr stage field runs 0, 31, 30.
  - TbValid count is 3.
- All-zero RAM, StartState=63, TB_LEN=6:
  - TbBit always 0.
  - States go 31, 15, 7, 3, 1, 0; FinalState=0.
- Start asserted again while Busy=1, and again coincident with Done:
  - Both ignored.
  - Exactly one Done and TB_LEN TbValid pulses.
- Reset pulsed low during the READ of step 2:
  - Outputs return to 0 immediately; no Done.
  - A fresh Start afterwards completes normally.
